// File: rtl/pinball_pkg.sv
// ---------------------------------------------------------------------------
// pinball_pkg
// Shared types and constants for the main-screen game-logic blocks.
//   sched_state_t       : frame_update_scheduler FSM encoding
//   NUM_UPDATE_CLIENTS  : number of per-frame update clients
//   CLIENT_*            : fixed service order of the update clients
//   idx_width()         : width of an index into an n-entry vector (min 1)
// ---------------------------------------------------------------------------
package pinball_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } sched_state_t;

    localparam int NUM_UPDATE_CLIENTS = 4;

    // Lower index is served first within a frame.
    localparam int CLIENT_FLIPPERS  = 0;
    localparam int CLIENT_BALL      = 1;
    localparam int CLIENT_COLLISION = 2;
    localparam int CLIENT_SCORE     = 3;

    // A one-entry vector still needs a one-bit index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lowest_bit_picker.sv
// ---------------------------------------------------------------------------
// lowest_bit_picker
// Combinational priority encoder: reports the position of the lowest set bit
// of a mask.
//   mask_i  [N-1:0]   request mask
//   idx_o   [IDX_W-1:0] index of the lowest set bit (0 when mask is empty)
//   found_o           mask has at least one bit set
// ---------------------------------------------------------------------------
module lowest_bit_picker
    import pinball_pkg::*;
#(
    parameter int N     = NUM_UPDATE_CLIENTS,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = |mask_i;
        // Scan from the top so the last (lowest) set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/frame_update_scheduler.sv
// ---------------------------------------------------------------------------
// frame_update_scheduler
// On each startOfFrame (while the game is running) latches the client request
// mask and hands a one-cycle update strobe to each requesting client in index
// order, waiting for that client's done (or a timeout) before moving on.
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        game running; low aborts the sequence and holds IDLE
//   startOfFrame  one-cycle frame pulse
//   req           per-client update request, sampled at frame start
//   done          per-client completion (level or pulse)
//   update        one-hot, one-cycle update strobe (registered)
//   busy          FSM not in IDLE
//   frameDone     pulse when all latched requests are served
//   overrun       pulse: startOfFrame arrived while busy (frame dropped)
//   timeoutErr    pulse: current client exceeded TIMEOUT_CYCLES
//   frameCount    completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module frame_update_scheduler
    import pinball_pkg::*;
#(
    parameter int NUM_CLIENTS    = NUM_UPDATE_CLIENTS,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FCNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   startOfFrame,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] update,
    output logic                   busy,
    output logic                   frameDone,
    output logic                   overrun,
    output logic                   timeoutErr,
    output logic [FCNT_W-1:0]      frameCount
);

    localparam int IDX_W   = idx_width(NUM_CLIENTS);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    sched_state_t            state_q,      state_d;
    logic [NUM_CLIENTS-1:0]  pending_q,    pending_d;
    logic [IDX_W-1:0]        idx_q,        idx_d;
    logic [TIMER_W-1:0]      timer_q,      timer_d;
    logic [NUM_CLIENTS-1:0]  update_q,     update_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q,    overrun_d;
    logic                    timeout_q,    timeout_d;
    logic [FCNT_W-1:0]       fcount_q,     fcount_d;

    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;

    lowest_bit_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .mask_i  (pending_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        update_d     = '0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        fcount_d     = fcount_q;
        // A new frame while a sequence is running is dropped, only flagged.
        overrun_d    = (state_q != IDLE) && startOfFrame;

        if (!enable) begin
            state_d   = IDLE;
            pending_d = '0;
            timer_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startOfFrame) begin
                        pending_d = req;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    if (pick_found) begin
                        update_d[pick_idx] = 1'b1;
                        idx_d   = pick_idx;
                        timer_d = '0;
                        state_d = WAIT;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = FINISH;
                    end
                end
                WAIT: begin
                    // The first WAIT cycle is the strobe cycle itself; a done
                    // seen there predates the update and is not accepted.
                    if (update_q == '0 && done[idx_q]) begin
                        pending_d[idx_q] = 1'b0;
                        state_d          = ISSUE;
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_d        = 1'b1;
                        pending_d[idx_q] = 1'b0;
                        state_d          = ISSUE;
                    end else if (timer_q != TIMER_MAX) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                FINISH: begin
                    fcount_d = fcount_q + 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            update_q     <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            fcount_q     <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            update_q     <= update_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            fcount_q     <= fcount_d;
        end
    end

    assign update     = update_q;
    assign busy       = (state_q != IDLE);
    assign frameDone  = frame_done_q;
    assign overrun    = overrun_q;
    assign timeoutErr = timeout_q;
    assign frameCount = fcount_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
module tb_frame_update_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       startOfFrame;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] update;
    logic       busy;
    logic       frameDone;
    logic       overrun;
    logic       timeoutErr;
    logic [7:0] frameCount;

    int checks = 0;
    int errors = 0;

    frame_update_scheduler #(
        .NUM_CLIENTS    (4),
        .TIMEOUT_CYCLES (16),
        .FCNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .startOfFrame (startOfFrame),
        .req          (req),
        .done         (done),
        .update       (update),
        .busy         (busy),
        .frameDone    (frameDone),
        .overrun      (overrun),
        .timeoutErr   (timeoutErr),
        .frameCount   (frameCount)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       en;
        logic       sof;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] upd;
        logic       busy;
        logic       fd;
        logic       ov;
        logic       to;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic v(input logic en, input logic sof, input logic [3:0] rq, input logic [3:0] dn,
                     input logic [3:0] upd, input logic bsy, input logic fd, input logic ov,
                     input logic to, input logic [7:0] fc);
        vec_t x;
        x.en = en; x.sof = sof; x.req = rq; x.done = dn;
        x.upd = upd; x.busy = bsy; x.fd = fd; x.ov = ov; x.to = to; x.fc = fc;
        vecs.push_back(x);
    endtask

    // Advance to just after the next rising edge; outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " update"},     32'(update),     0);
        chk({tag, " busy"},       32'(busy),       0);
        chk({tag, " frameDone"},  32'(frameDone),  0);
        chk({tag, " overrun"},    32'(overrun),    0);
        chk({tag, " timeoutErr"}, 32'(timeoutErr), 0);
        chk({tag, " frameCount"}, 32'(frameCount), 0);
    endtask

    initial begin
        int bad;
        int ov_cnt;
        int fd_cnt;
        int upd_cnt;
        int fd_cycle;
        int got;

        reset = 1'b1; enable = 1'b0; startOfFrame = 1'b0; req = '0; done = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // ---- table: ordered service, empty frame, enable-low frame ignored
        //  en sof req      done     upd      busy fd ov to fc
        v(1, 1, 4'b1011, 4'b0000, 4'b0000, 0, 0, 0, 0, 0); // c0  frame start
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c1  ISSUE, req change ignored
        v(1, 0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 0); // c2  update client 0
        v(1, 0, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0, 0); // c3  foreign done ignored
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c4
        v(1, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0, 0); // c5  done 0
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c6  ISSUE
        v(1, 0, 4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 0, 0); // c7  update 1, same-cycle done ignored
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c8
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c9
        v(1, 0, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 0, 0); // c10 done 1
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c11 ISSUE
        v(1, 0, 4'b0000, 4'b0000, 4'b1000, 1, 0, 0, 0, 0); // c12 update 3
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c13
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c14
        v(1, 0, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 0, 0); // c15 done 3
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0); // c16 ISSUE, nothing left
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 0); // c17 FINISH, frameDone
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1); // c18 IDLE, count 1
        v(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1); // c19 empty frame start
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 1); // c20 ISSUE
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 1); // c21 frameDone at k+2
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 2); // c22 IDLE
        v(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 2); // c23 frame with enable low
        v(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 2); // c24 still idle
        v(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 2); // c25

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en; startOfFrame = vecs[i].sof;
            req = vecs[i].req; done = vecs[i].done;
            $display("vec %0d en=%0b sof=%0b req=%b done=%b -> upd=%b busy=%0b fd=%0b ov=%0b to=%0b fc=%0d",
                     i, enable, startOfFrame, req, done, update, busy, frameDone, overrun, timeoutErr, frameCount);
            chk($sformatf("vec%0d update", i),     32'(update),     32'(vecs[i].upd));
            chk($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].busy));
            chk($sformatf("vec%0d frameDone", i),  32'(frameDone),  32'(vecs[i].fd));
            chk($sformatf("vec%0d overrun", i),    32'(overrun),    32'(vecs[i].ov));
            chk($sformatf("vec%0d timeoutErr", i), 32'(timeoutErr), 32'(vecs[i].to));
            chk($sformatf("vec%0d frameCount", i), 32'(frameCount), 32'(vecs[i].fc));
            tick();
        end
        startOfFrame = 1'b0; done = '0; req = '0;

        // ---- timeout: client 1 never answers
        startOfFrame = 1'b1; req = 4'b0010;
        tick(); startOfFrame = 1'b0; req = '0;
        tick();
        chk("to update_c1", 32'(update), 32'h2);
        bad = 0;
        for (int i = 3; i <= 17; i++) begin
            tick();
            if (timeoutErr || frameDone || update != 0) bad++;
        end
        chk("to early_events", 32'(bad), 0);
        tick();
        chk("to timeoutErr", 32'(timeoutErr), 1);
        tick();
        chk("to frameDone", 32'(frameDone), 1);
        chk("to timeoutErr_pulse", 32'(timeoutErr), 0);
        tick();
        chk("to busy_after", 32'(busy), 0);
        chk("to frameCount", 32'(frameCount), 3);
        $display("seq timeout fc=%0d", frameCount);

        // ---- overrun: second frame during WAIT is dropped
        startOfFrame = 1'b1; req = 4'b0001;
        tick(); startOfFrame = 1'b0; req = '0;
        tick();
        chk("ov update_c0", 32'(update), 32'h1);
        tick();
        startOfFrame = 1'b1; req = 4'b1111;
        tick();
        startOfFrame = 1'b0; req = '0;
        chk("ov overrun", 32'(overrun), 1);
        ov_cnt = 0; fd_cnt = 0; upd_cnt = 0; fd_cycle = -1;
        for (int i = 4; i <= 15; i++) begin
            done = (i == 5) ? 4'b0001 : 4'b0000;
            if (overrun) ov_cnt++;
            if (update != 0) upd_cnt++;
            if (frameDone) begin fd_cnt++; fd_cycle = i; end
            tick();
        end
        done = '0;
        chk("ov overrun_count", 32'(ov_cnt), 1);
        chk("ov frameDone_count", 32'(fd_cnt), 1);
        chk("ov frameDone_cycle", 32'(fd_cycle), 7);
        chk("ov no_new_updates", 32'(upd_cnt), 0);
        chk("ov frameCount", 32'(frameCount), 4);
        $display("seq overrun ov=%0d fd=%0d fd_cycle=%0d fc=%0d", ov_cnt, fd_cnt, fd_cycle, frameCount);

        // ---- enable dropped while waiting on client 1
        startOfFrame = 1'b1; req = 4'b0011;
        tick(); startOfFrame = 1'b0; req = '0;
        tick();
        chk("en update_c0", 32'(update), 32'h1);
        tick(); done = 4'b0001;
        tick(); done = '0;
        tick();
        chk("en update_c1", 32'(update), 32'h2);
        tick(); enable = 1'b0;
        tick();
        chk("en busy_dropped", 32'(busy), 0);
        enable = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frameDone || busy) fd_cnt++;
        end
        chk("en no_finish", 32'(fd_cnt), 0);
        chk("en frameCount_kept", 32'(frameCount), 4);
        startOfFrame = 1'b1; req = 4'b0011;
        tick(); startOfFrame = 1'b0; req = '0;
        tick();
        chk("en restart_c0", 32'(update), 32'h1);
        done = 4'b0011;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            tick();
            if (frameDone) got = 1;
        end
        chk("en second_frame_done", 32'(got), 1);
        done = '0;
        tick();
        chk("en frameCount_next", 32'(frameCount), 5);
        $display("seq enable_drop fc=%0d", frameCount);

        // ---- asynchronous reset mid-WAIT, then 256 back-to-back frames
        startOfFrame = 1'b1; req = 4'b0001;
        tick(); startOfFrame = 1'b0; req = '0;
        tick();
        chk("rst busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("rst async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all_zero("rst held");
        fd_cnt = 0; ov_cnt = 0;
        for (int f = 0; f < 256; f++) begin
            startOfFrame = 1'b1;
            tick(); startOfFrame = 1'b0;
            if (frameDone) fd_cnt++;
            if (overrun) ov_cnt++;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (frameDone) fd_cnt++;
                if (overrun) ov_cnt++;
            end
            if (f == 254) chk("wrap count_255", 32'(frameCount), 255);
        end
        chk("wrap count_0", 32'(frameCount), 0);
        chk("wrap frameDone_count", 32'(fd_cnt), 256);
        chk("wrap overrun_count", 32'(ov_cnt), 0);
        $display("seq wrap fd=%0d fc=%0d", fd_cnt, frameCount);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
